// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared FSM states, request sources, default latencies
package mem_responder_pkg;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;
  typedef enum logic {SRC_ROM, SRC_RAM} src_t;
  localparam int DEF_READ_LAT = 3;
  localparam int DEF_WRITE_LAT = 1;
  function automatic int lat_w(input int rl, input int wl);
    return $clog2((rl > wl ? rl : wl) + 1);
  endfunction
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: general bus between control unit (master) and memory responder (slave)
interface mem_responder_if #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 12
);
  logic rom_rd;
  logic ram_rd;
  logic ram_wr;
  logic [ADDR_W-1:0] addr_out;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_in;
  logic rd_valid;
  logic wr_ack;
  logic busy;
  logic bus_err;
  modport master (
    output rom_rd, ram_rd, ram_wr, addr_out, data_out,
    input data_in, rd_valid, wr_ack, busy, bus_err
  );
  modport slave (
    input rom_rd, ram_rd, ram_wr, addr_out, data_out,
    output data_in, rd_valid, wr_ack, busy, bus_err
  );
endinterface

// File: rtl/mem_responder_sp_mem_array.sv
// mem_responder_sp_mem_array: synchronous single-port memory array with registered read
module mem_responder_sp_mem_array #(
  parameter int DEPTH = 1024,
  parameter int DATA_W = 14
) (
  input  logic clk,
  input  logic we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: serves ROM/RAM bus requests with fixed latency, range check and error reporting
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 12,
  parameter int ROM_DEPTH = 4096,
  parameter int RAM_DEPTH = 1024,
  parameter int READ_LAT = DEF_READ_LAT,
  parameter int WRITE_LAT = DEF_WRITE_LAT
) (
  input logic clk,
  input logic reset,
  mem_responder_if.slave bus
);
  localparam int CW = lat_w(READ_LAT, WRITE_LAT);
  localparam int ROM_AW = $clog2(ROM_DEPTH);
  localparam int RAM_AW = $clog2(RAM_DEPTH);
  state_t state, state_nx;
  src_t src, src_nx;
  logic [CW-1:0] lat_cnt, lat_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx, mem_addr;
  logic [DATA_W-1:0] wdata_q, wdata_nx, data_q, data_nx, rom_q, ram_q;
  logic wr_q, wr_nx, ram_we, lat_zero, err;
  assign lat_zero = lat_cnt == '0;
  assign err = src == SRC_ROM ? 32'(addr_q) >= ROM_DEPTH : 32'(addr_q) >= RAM_DEPTH;
  assign mem_addr = state == IDLE ? bus.addr_out : addr_q;
  assign bus.data_in = data_q;
  assign bus.busy = state == RD_WAIT || state == WR_WAIT;
  assign bus.rd_valid = state == RESP && !wr_q;
  assign bus.wr_ack = state == RESP && wr_q;
  assign bus.bus_err = state == RESP && err;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      src <= SRC_ROM;
      lat_cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wr_q <= 1'b0;
      data_q <= '0;
    end else begin
      state <= state_nx;
      src <= src_nx;
      lat_cnt <= lat_nx;
      addr_q <= addr_nx;
      wdata_q <= wdata_nx;
      wr_q <= wr_nx;
      data_q <= data_nx;
    end
  always_comb begin
    state_nx = state;
    src_nx = src;
    lat_nx = lat_cnt;
    addr_nx = addr_q;
    wdata_nx = wdata_q;
    wr_nx = wr_q;
    data_nx = data_q;
    ram_we = 1'b0;
    case (state)
      IDLE: if (bus.ram_wr || bus.ram_rd || bus.rom_rd) begin
        state_nx = bus.ram_wr ? WR_WAIT : RD_WAIT;
        src_nx = (bus.ram_wr || bus.ram_rd) ? SRC_RAM : SRC_ROM;
        wr_nx = bus.ram_wr;
        lat_nx = bus.ram_wr ? CW'(WRITE_LAT - 1) : CW'(READ_LAT - 1);
        addr_nx = bus.addr_out;
        wdata_nx = bus.data_out;
      end
      RD_WAIT: begin
        state_nx = lat_zero ? RESP : RD_WAIT;
        lat_nx = lat_zero ? lat_cnt : lat_cnt - CW'(1);
        data_nx = !lat_zero ? data_q : err ? '0 : src == SRC_ROM ? rom_q : ram_q;
      end
      WR_WAIT: begin
        state_nx = lat_zero ? RESP : WR_WAIT;
        lat_nx = lat_zero ? lat_cnt : lat_cnt - CW'(1);
        ram_we = lat_zero && !err;
      end
      default: state_nx = IDLE;
    endcase
  end
  mem_responder_sp_mem_array #(.DEPTH(ROM_DEPTH), .DATA_W(DATA_W)) u_rom (
    .clk(clk),
    .we(1'b0),
    .addr(mem_addr[ROM_AW-1:0]),
    .wdata('0),
    .rdata(rom_q)
  );
  mem_responder_sp_mem_array #(.DEPTH(RAM_DEPTH), .DATA_W(DATA_W)) u_ram (
    .clk(clk),
    .we(ram_we),
    .addr(mem_addr[RAM_AW-1:0]),
    .wdata(wdata_q),
    .rdata(ram_q)
  );
endmodule
